// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all channel resets, releases them in ascending order with programmable
// gaps, and performs an ordered descending shutdown followed by clock gating.
module reset_sequencer #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DELAY_W     = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         resn,
  input  logic [CHANNELS*DELAY_W-1:0]  delay_cfg,
  input  logic                         soft_rst_req,
  input  logic                         shutdown_req,
  output logic [CHANNELS-1:0]          channel_resn,
  output logic [CHANNELS-1:0]          channel_clk_en,
  output logic                         busy,
  output logic                         all_running,
  output logic                         all_reset,
  output logic [2:0]                   state
);

  localparam int unsigned GapSpan  = 2 ** DELAY_W;
  localparam int unsigned MaxCount = (HOLD_CYCLES > GapSpan) ? HOLD_CYCLES : GapSpan;
  // Wide enough to hold MaxCount itself, so neither the hold nor a full gap can wrap.
  localparam int unsigned CntW     = $clog2(MaxCount + 1);
  localparam int unsigned IdxW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CntW-1:0] CntZero  = '0;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxZero  = '0;
  localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StRelease  = 3'd1,
    StRun      = 3'd2,
    StShutdown = 3'd3,
    StGate     = 3'd4,
    StOff      = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DELAY_W-1:0]    gap_q, gap_d;
  logic [CHANNELS-1:0]   resn_q, resn_d;
  logic [CHANNELS-1:0]   clk_en_q, clk_en_d;
  logic                  busy_q, busy_d;
  logic                  running_q, running_d;
  logic                  all_reset_q, all_reset_d;

  logic [DELAY_W-1:0]    gap_tbl [CHANNELS];
  logic [IdxW-1:0]       idx_up, idx_dn;
  logic                  gap_done;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_gap_tbl
    assign gap_tbl[i] = delay_cfg[i*DELAY_W +: DELAY_W];
  end

  assign idx_up   = idx_q + IdxOne;
  assign idx_dn   = idx_q - IdxOne;
  assign gap_done = (cnt_q == CntW'(gap_q));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    resn_d   = resn_q;
    clk_en_d = clk_en_q;

    case (state_q)
      StHold: begin
        if (shutdown_req) begin
          // Every reset is already low, so go straight to clock gating.
          state_d = StGate;
          cnt_d   = CntZero;
        end else if (soft_rst_req) begin
          cnt_d = CntZero;
        end else if (cnt_q == HoldLast) begin
          state_d = StRelease;
          idx_d   = IdxZero;
          gap_d   = gap_tbl[0];
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StRelease: begin
        if (shutdown_req) begin
          cnt_d = CntZero;
          if (idx_q == IdxZero) begin
            state_d = StGate;
          end else begin
            state_d = StShutdown;
            idx_d   = idx_dn;
            gap_d   = gap_tbl[idx_dn];
          end
        end else if (soft_rst_req) begin
          state_d = StHold;
          resn_d  = '0;
          cnt_d   = CntZero;
        end else if (gap_done) begin
          resn_d[idx_q] = 1'b1;
          cnt_d         = CntZero;
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else begin
            idx_d = idx_up;
            gap_d = gap_tbl[idx_up];
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StRun: begin
        if (shutdown_req) begin
          state_d = StShutdown;
          idx_d   = IdxLast;
          gap_d   = gap_tbl[IdxLast];
          cnt_d   = CntZero;
        end else if (soft_rst_req) begin
          state_d = StHold;
          resn_d  = '0;
          cnt_d   = CntZero;
        end
      end

      StShutdown: begin
        if (gap_done) begin
          resn_d[idx_q] = 1'b0;
          cnt_d         = CntZero;
          if (idx_q == IdxZero) begin
            state_d = StGate;
          end else begin
            idx_d = idx_dn;
            gap_d = gap_tbl[idx_dn];
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StGate: begin
        if (cnt_q == HoldLast) begin
          state_d  = StOff;
          clk_en_d = '0;
          cnt_d    = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StOff: begin
        // Clocks come back while resets stay low through the following hold.
        if (!shutdown_req) begin
          state_d  = StHold;
          clk_en_d = '1;
          cnt_d    = CntZero;
        end
      end

      default: begin
        state_d  = StHold;
        resn_d   = '0;
        clk_en_d = '1;
        cnt_d    = CntZero;
        idx_d    = IdxZero;
      end
    endcase

    busy_d      = (state_d != StRun) && (state_d != StOff);
    running_d   = (state_d == StRun);
    all_reset_d = (resn_d == '0);
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q     <= StHold;
      cnt_q       <= CntZero;
      idx_q       <= IdxZero;
      gap_q       <= '0;
      resn_q      <= '0;
      clk_en_q    <= '1;
      busy_q      <= 1'b1;
      running_q   <= 1'b0;
      all_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      resn_q      <= resn_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
      all_reset_q <= all_reset_d;
    end
  end

  assign channel_resn   = resn_q;
  assign channel_clk_en = clk_en_q;
  assign busy           = busy_q;
  assign all_running    = running_q;
  assign all_reset      = all_reset_q;
  assign state          = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: edge numbers count posedges after resn is released.
module tb_reset_sequencer;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned HC = 16;

  logic              clk = 1'b0;
  logic              resn;
  logic [CH*DW-1:0]  delay_cfg;
  logic              soft_rst_req;
  logic              shutdown_req;
  logic [CH-1:0]     channel_resn;
  logic [CH-1:0]     channel_clk_en;
  logic              busy;
  logic              all_running;
  logic              all_reset;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;
  int ec     = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .CHANNELS    (CH),
    .DELAY_W     (DW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk            (clk),
    .resn           (resn),
    .delay_cfg      (delay_cfg),
    .soft_rst_req   (soft_rst_req),
    .shutdown_req   (shutdown_req),
    .channel_resn   (channel_resn),
    .channel_clk_en (channel_clk_en),
    .busy           (busy),
    .all_running    (all_running),
    .all_reset      (all_reset),
    .state          (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after absolute edge n.
  task automatic to_edge(input int n);
    repeat (n - ec) @(posedge clk);
    #1;
    ec = n;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"},       32'(state),          32'd0);
    chk({tag, ".resn"},        32'(channel_resn),   32'h0);
    chk({tag, ".clk_en"},      32'(channel_clk_en), 32'hF);
    chk({tag, ".busy"},        32'(busy),           32'd1);
    chk({tag, ".all_running"}, 32'(all_running),    32'd0);
    chk({tag, ".all_reset"},   32'(all_reset),      32'd1);
  endtask

  initial begin
    resn         = 1'b0;
    soft_rst_req = 1'b0;
    shutdown_req = 1'b0;
    delay_cfg    = {8'd2, 8'd2, 8'd2, 8'd2};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");

    @(negedge clk);
    resn = 1'b1;
    ec   = 0;

    // Power-on sequence, gaps of 2.
    to_edge(15); chk("hold15.state", 32'(state), 32'd0);
    to_edge(16); chk("rel16.state", 32'(state), 32'd1);
    to_edge(18); chk("e18.resn", 32'(channel_resn), 32'h0);
                 chk("e18.all_reset", 32'(all_reset), 32'd1);
    to_edge(19); chk("e19.resn", 32'(channel_resn), 32'h1);
                 chk("e19.all_reset", 32'(all_reset), 32'd0);
    to_edge(22); chk("e22.resn", 32'(channel_resn), 32'h3);
    to_edge(25); chk("e25.resn", 32'(channel_resn), 32'h7);
    to_edge(27); chk("e27.state", 32'(state), 32'd1);
                 chk("e27.busy", 32'(busy), 32'd1);
                 chk("e27.all_running", 32'(all_running), 32'd0);
    to_edge(28); chk("e28.resn", 32'(channel_resn), 32'hF);
                 chk("e28.state", 32'(state), 32'd2);
                 chk("e28.all_running", 32'(all_running), 32'd1);
                 chk("e28.busy", 32'(busy), 32'd0);

    // One-cycle soft reset from RUN.
    soft_rst_req = 1'b1;
    to_edge(29); soft_rst_req = 1'b0;
                 chk("sr29.state", 32'(state), 32'd0);
                 chk("sr29.resn", 32'(channel_resn), 32'h0);
                 chk("sr29.all_reset", 32'(all_reset), 32'd1);
                 chk("sr29.busy", 32'(busy), 32'd1);
    to_edge(44); chk("sr44.state", 32'(state), 32'd0);
    to_edge(45); chk("sr45.state", 32'(state), 32'd1);
    to_edge(47); chk("sr47.resn", 32'(channel_resn), 32'h0);
    to_edge(48); chk("sr48.resn", 32'(channel_resn), 32'h1);
    to_edge(57); chk("sr57.resn", 32'(channel_resn), 32'hF);
                 chk("sr57.state", 32'(state), 32'd2);

    // Shutdown and soft reset together in RUN; shutdown wins. Gaps of 1.
    delay_cfg    = {8'd1, 8'd1, 8'd1, 8'd1};
    shutdown_req = 1'b1;
    soft_rst_req = 1'b1;
    to_edge(58); soft_rst_req = 1'b0;
                 chk("sd58.state", 32'(state), 32'd3);
                 chk("sd58.resn", 32'(channel_resn), 32'hF);
    to_edge(59); chk("sd59.resn", 32'(channel_resn), 32'hF);
    to_edge(60); chk("sd60.resn", 32'(channel_resn), 32'h7);
    to_edge(62); chk("sd62.resn", 32'(channel_resn), 32'h3);
    to_edge(64); chk("sd64.resn", 32'(channel_resn), 32'h1);
    to_edge(66); chk("sd66.resn", 32'(channel_resn), 32'h0);
                 chk("sd66.state", 32'(state), 32'd4);
                 chk("sd66.all_reset", 32'(all_reset), 32'd1);
    to_edge(81); chk("g81.state", 32'(state), 32'd4);
                 chk("g81.clk_en", 32'(channel_clk_en), 32'hF);
    to_edge(82); chk("off82.state", 32'(state), 32'd5);
                 chk("off82.clk_en", 32'(channel_clk_en), 32'h0);
                 chk("off82.busy", 32'(busy), 32'd0);
    soft_rst_req = 1'b1;
    to_edge(85); chk("off85.state", 32'(state), 32'd5);
    soft_rst_req = 1'b0;
    shutdown_req = 1'b0;
    to_edge(86); chk("up86.state", 32'(state), 32'd0);
                 chk("up86.clk_en", 32'(channel_clk_en), 32'hF);
                 chk("up86.busy", 32'(busy), 32'd1);
    to_edge(102); chk("up102.state", 32'(state), 32'd1);
    to_edge(104); chk("up104.resn", 32'(channel_resn), 32'h1);
    to_edge(110); chk("up110.resn", 32'(channel_resn), 32'hF);
                  chk("up110.state", 32'(state), 32'd2);

    // Shutdown during RELEASE after two channels are out of reset.
    soft_rst_req = 1'b1;
    to_edge(111); soft_rst_req = 1'b0;
    to_edge(131); chk("mr131.resn", 32'(channel_resn), 32'h3);
    shutdown_req = 1'b1;
    to_edge(132); chk("mr132.state", 32'(state), 32'd3);
                  chk("mr132.resn", 32'(channel_resn), 32'h3);
    to_edge(134); chk("mr134.resn", 32'(channel_resn), 32'h1);
    to_edge(136); chk("mr136.resn", 32'(channel_resn), 32'h0);
                  chk("mr136.state", 32'(state), 32'd4);
    to_edge(152); chk("mr152.state", 32'(state), 32'd5);

    // Uneven gaps {0,5,0,255}, including the widest gap.
    delay_cfg    = {8'd255, 8'd0, 8'd5, 8'd0};
    shutdown_req = 1'b0;
    to_edge(153); chk("ug153.state", 32'(state), 32'd0);
    to_edge(169); chk("ug169.state", 32'(state), 32'd1);
                  chk("ug169.resn", 32'(channel_resn), 32'h0);
    to_edge(170); chk("ug170.resn", 32'(channel_resn), 32'h1);
    to_edge(175); chk("ug175.resn", 32'(channel_resn), 32'h1);
    to_edge(176); chk("ug176.resn", 32'(channel_resn), 32'h3);
    to_edge(177); chk("ug177.resn", 32'(channel_resn), 32'h7);
    to_edge(432); chk("ug432.resn", 32'(channel_resn), 32'h7);
                  chk("ug432.state", 32'(state), 32'd1);
    to_edge(433); chk("ug433.resn", 32'(channel_resn), 32'hF);
                  chk("ug433.state", 32'(state), 32'd2);

    // Soft reset inside HOLD restarts the hold count.
    soft_rst_req = 1'b1;
    to_edge(434); soft_rst_req = 1'b0;
                  chk("hr434.state", 32'(state), 32'd0);
    to_edge(440); soft_rst_req = 1'b1;
    to_edge(441); soft_rst_req = 1'b0;
    to_edge(450); chk("hr450.state", 32'(state), 32'd0);
    to_edge(456); chk("hr456.state", 32'(state), 32'd0);
    to_edge(457); chk("hr457.state", 32'(state), 32'd1);

    // Shutdown in RELEASE before any channel is released goes straight to GATE.
    shutdown_req = 1'b1;
    to_edge(458); chk("ng458.state", 32'(state), 32'd4);
                  chk("ng458.resn", 32'(channel_resn), 32'h0);
    to_edge(474); chk("ng474.state", 32'(state), 32'd5);
                  chk("ng474.clk_en", 32'(channel_clk_en), 32'h0);

    // Asynchronous reset between clock edges while OFF.
    #3;
    resn = 1'b0;
    #1;
    chk_reset_vals("async");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
